// File: rtl/k12_fetch_if.sv
// k12 fetch bus: byte memory port plus the instruction handshake
// and branch feedback shared with the execute stage.
interface k12_fetch_if #(
  parameter int PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] mem_addr;
  logic                mem_rd;
  logic [7:0]          mem_data;
  logic                mem_ack;
  logic [15:0]         inst;
  logic                inst_valid;
  logic                inst_ready;
  logic                cond;
  logic                branch_en;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] pc;

  modport master (
    output mem_addr, mem_rd, inst,
    output inst_valid, pc,
    input  mem_data, mem_ack, inst_ready,
    input  cond, branch_en, branch_target
  );

  modport slave (
    input  mem_addr, mem_rd, inst,
    input  inst_valid, pc,
    output mem_data, mem_ack, inst_ready,
    output cond, branch_en, branch_target
  );
endinterface

// File: rtl/k12_fetch.sv
// k12 fetch stage: two big-endian byte reads per instruction,
// held until execute accepts it; taken branches load the PC.
module k12_fetch #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst,
  k12_fetch_if.master fetch
);

  localparam logic [1:0] S_HI   = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_inst;
  logic                w_rd;
  logic                w_valid;
  logic                w_take;

  // Outputs come from state only; rst just masks them.
  assign w_rd    = (r_state == S_HI || r_state == S_LO) && !rst;
  assign w_valid = (r_state == S_HOLD) && !rst;
  assign w_take  = fetch.branch_en & fetch.cond;

  assign fetch.mem_addr   = r_pc;
  assign fetch.pc         = r_pc;
  assign fetch.mem_rd     = w_rd;
  assign fetch.inst       = r_inst;
  assign fetch.inst_valid = w_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HI;
      r_pc    <= RESET_PC;
      r_inst  <= 16'h0000;
    end else begin
      unique case (1'b1)
        r_state == S_HI: begin
          if (fetch.mem_ack) begin
            r_inst[15:8] <= fetch.mem_data;
            r_pc         <= r_pc + PC_WIDTH'(1);
            r_state      <= S_LO;
          end
        end
        r_state == S_LO: begin
          if (fetch.mem_ack) begin
            r_inst[7:0] <= fetch.mem_data;
            r_pc        <= r_pc + PC_WIDTH'(1);
            r_state     <= S_HOLD;
          end
        end
        r_state == S_HOLD: begin
          if (fetch.inst_ready) begin
            if (w_take) r_pc <= fetch.branch_target;
            r_state <= S_HI;
          end
        end
        default: r_state <= S_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_k12_fetch.sv
// Directed bench for k12_fetch: two instances, RESET_PC 0
// and RESET_PC FFFF, sharing one byte memory image.
module tb_k12_fetch;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] mem [0:65535];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  k12_fetch_if #(.PC_WIDTH(16)) a ();
  k12_fetch_if #(.PC_WIDTH(16)) b ();

  k12_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) u_a (
    .clk   (clk),
    .rst   (rst),
    .fetch (a.master)
  );

  k12_fetch #(.PC_WIDTH(16), .RESET_PC(16'hFFFF)) u_b (
    .clk   (clk),
    .rst   (rst),
    .fetch (b.master)
  );

  assign a.mem_data = mem[a.mem_addr];
  assign b.mem_data = mem[b.mem_addr];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34;
    mem[16'h0002] = 8'h56; mem[16'h0003] = 8'h78;
    mem[16'h0100] = 8'hAB; mem[16'h0101] = 8'hCD;
    mem[16'h0102] = 8'h9A; mem[16'h0103] = 8'hBC;
    mem[16'h0104] = 8'h11; mem[16'h0105] = 8'h22;
    mem[16'hFFFF] = 8'hEE;

    rst = 1'b1;
    a.mem_ack = 1'b1; a.inst_ready = 1'b0;
    a.cond = 1'b0; a.branch_en = 1'b0; a.branch_target = '0;
    b.mem_ack = 1'b1; b.inst_ready = 1'b0;
    b.cond = 1'b0; b.branch_en = 1'b0; b.branch_target = '0;

    repeat (2) @(negedge clk);
    check("rst_rd", 32'(a.mem_rd), 0);
    check("rst_valid", 32'(a.inst_valid), 0);
    check("rst_inst", 32'(a.inst), 0);
    check("rst_pc", 32'(a.pc), 0);
    check("rst_pc_b", 32'(b.pc), 32'hFFFF);

    // cycle 0 of first fetch
    rst = 1'b0;
    #1;
    check("c0_rd", 32'(a.mem_rd), 1);
    check("c0_addr", 32'(a.mem_addr), 0);
    check("c0_addr_b", 32'(b.mem_addr), 32'hFFFF);
    @(negedge clk);
    check("c1_addr", 32'(a.mem_addr), 1);
    check("c1_valid", 32'(a.inst_valid), 0);
    check("c1_addr_b", 32'(b.mem_addr), 0);
    @(negedge clk);
    check("c2_valid", 32'(a.inst_valid), 1);
    check("c2_inst", 32'(a.inst), 32'h1234);
    check("c2_pc", 32'(a.pc), 2);
    check("c2_rd", 32'(a.mem_rd), 0);
    check("c2_inst_b", 32'(b.inst), 32'hEE12);
    check("c2_pc_b", 32'(b.pc), 1);
    b.inst_ready = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b.inst_ready = 1'b0;
      if (i == 0) check("acc_addr_b", 32'(b.mem_addr), 1);
      check("hold_inst", 32'(a.inst), 32'h1234);
      check("hold_pc", 32'(a.pc), 2);
      check("hold_rd", 32'(a.mem_rd), 0);
      check("hold_valid", 32'(a.inst_valid), 1);
    end

    a.inst_ready = 1'b1;
    @(negedge clk);
    a.inst_ready = 1'b0;
    check("acc_addr", 32'(a.mem_addr), 2);
    check("acc_valid", 32'(a.inst_valid), 0);
    check("acc_rd", 32'(a.mem_rd), 1);
    repeat (2) @(negedge clk);
    check("i2_inst", 32'(a.inst), 32'h5678);
    check("i2_valid", 32'(a.inst_valid), 1);

    // taken branch
    a.branch_en = 1'b1; a.cond = 1'b1;
    a.branch_target = 16'h0100; a.inst_ready = 1'b1;
    @(negedge clk);
    a.inst_ready = 1'b0; a.branch_en = 1'b0; a.cond = 1'b0;
    check("br_addr", 32'(a.mem_addr), 32'h0100);
    repeat (2) @(negedge clk);
    check("br_inst", 32'(a.inst), 32'hABCD);
    check("br_pc", 32'(a.pc), 32'h0102);

    // branch with cond low falls through
    a.branch_en = 1'b1; a.cond = 1'b0;
    a.branch_target = 16'h0200; a.inst_ready = 1'b1;
    @(negedge clk);
    a.inst_ready = 1'b0; a.branch_en = 1'b0;
    check("nt_addr", 32'(a.mem_addr), 32'h0102);

    // three wait cycles in each byte phase
    for (int c = 0; c < 8; c++) begin
      a.mem_ack = (c == 3 || c == 7);
      check("ws_addr", 32'(a.mem_addr),
            (c < 4) ? 32'h0102 : 32'h0103);
      check("ws_rd", 32'(a.mem_rd), 1);
      check("ws_valid", 32'(a.inst_valid), 0);
      @(negedge clk);
    end
    a.mem_ack = 1'b1;
    check("ws_valid8", 32'(a.inst_valid), 1);
    check("ws_inst", 32'(a.inst), 32'h9ABC);

    // reset in the middle of FETCH_LO
    a.inst_ready = 1'b1;
    @(negedge clk);
    a.inst_ready = 1'b0;
    check("mr_hi_addr", 32'(a.mem_addr), 32'h0104);
    @(negedge clk);
    check("mr_lo_addr", 32'(a.mem_addr), 32'h0105);
    rst = 1'b1;
    #1;
    check("mr_rd", 32'(a.mem_rd), 0);
    check("mr_valid", 32'(a.inst_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_inst", 32'(a.inst), 0);
    check("mr_pc", 32'(a.pc), 0);
    check("mr_rd2", 32'(a.mem_rd), 1);
    @(negedge clk);
    check("mr_c1_valid", 32'(a.inst_valid), 0);
    check("mr_c1_addr", 32'(a.mem_addr), 1);
    @(negedge clk);
    check("mr_c2_valid", 32'(a.inst_valid), 1);
    check("mr_c2_inst", 32'(a.inst), 32'h1234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
